// File: rtl/user_wb_page_sequencer.sv
`timescale 1ns/1ps
// Wishbone user-window page sequencer: decodes A[19:16] onto one of NUM_SLV page-mapped
// slaves, and always closes the bus with a normal ack, an unmapped error-ack or a watchdog ack.
module user_wb_page_sequencer #(
  parameter int                   NUM_SLV  = 2,
  parameter logic [4*NUM_SLV-1:0] PAGE_LO  = 8'h80,
  parameter logic [4*NUM_SLV-1:0] PAGE_HI  = 8'hC7,
  parameter int                   TIMEOUT  = 255,
  parameter logic [31:0]          ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    slv_cyc_o,
  output logic [NUM_SLV-1:0]      slv_stb_o,
  output logic                    slv_we_o,
  output logic [3:0]              slv_sel_o,
  output logic [31:0]             slv_adr_o,
  output logic [31:0]             slv_dat_o,
  input  logic [NUM_SLV-1:0]      slv_ack_i,
  input  logic [32*NUM_SLV-1:0]   slv_dat_i,
  input  logic                    err_clr_i,
  output logic                    err_unmap_o,
  output logic                    err_tmo_o,
  output logic [3:0]              err_page_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_RESP   = 3'd2,
    S_ERR    = 3'd3,
    S_TMO    = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_cnt;
  logic [NUM_SLV-1:0]   r_sel_oh;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic [31:0]          r_adr;
  logic [31:0]          r_dat;
  logic [31:0]          r_rdat;
  logic                 r_err_unmap;
  logic                 r_err_tmo;
  logic [3:0]           r_err_page;

  logic                 w_req;
  logic [3:0]           w_page;
  logic [NUM_SLV-1:0]   w_dec_oh;
  logic                 w_dec_hit;
  logic                 w_sel_ack;
  logic [31:0]          w_sel_dat;

  assign w_req  = wbs_cyc_i & wbs_stb_i;
  assign w_page = wbs_adr_i[19:16];

  // Ranges may overlap: scanning upward and stopping at the first hit gives the lowest index priority.
  always_comb begin
    w_dec_oh  = '0;
    w_dec_hit = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!w_dec_hit && (w_page >= PAGE_LO[4*k +: 4]) && (w_page <= PAGE_HI[4*k +: 4])) begin
        w_dec_oh[k] = 1'b1;
        w_dec_hit   = 1'b1;
      end
    end
  end

  // Only the latched slave's ack and data are observed; strays from other slaves are masked here.
  always_comb begin
    w_sel_ack = |(slv_ack_i & r_sel_oh);
    w_sel_dat = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_sel_oh[k]) w_sel_dat = w_sel_dat | slv_dat_i[32*k +: 32];
    end
  end

  always_comb begin
    w_next    = r_state;
    slv_cyc_o = 1'b0;
    slv_stb_o = '0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = w_dec_hit ? S_ACTIVE : S_ERR;
      end
      S_ACTIVE: begin
        slv_cyc_o = 1'b1;
        slv_stb_o = r_sel_oh;
        if (w_sel_ack)              w_next = S_RESP;
        else if (r_cnt == TMO_LAST) w_next = S_TMO;
        else if (!wbs_cyc_i)        w_next = S_IDLE;
      end
      S_RESP: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = r_rdat;
        w_next    = S_IDLE;
      end
      S_ERR, S_TMO: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = ERR_DATA;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel_oh    <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rdat      <= '0;
      r_err_unmap <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_page  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_sel_oh <= w_dec_oh;
            r_we     <= wbs_we_i;
            r_sel    <= wbs_sel_i;
            r_adr    <= wbs_adr_i;
            r_dat    <= wbs_dat_i;
          end
        end
        S_ACTIVE: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_sel_ack) r_rdat <= r_we ? 32'd0 : w_sel_dat;
        end
        default: ;
      endcase

      // Clear first so that an error reported in the same cycle overrides it.
      if (err_clr_i) begin
        r_err_unmap <= 1'b0;
        r_err_tmo   <= 1'b0;
      end
      if (r_state == S_ERR) begin
        r_err_unmap <= 1'b1;
        r_err_page  <= r_adr[19:16];
      end
      if (r_state == S_TMO) begin
        r_err_tmo  <= 1'b1;
        r_err_page <= r_adr[19:16];
      end
    end
  end

  assign slv_we_o    = r_we;
  assign slv_sel_o   = r_sel;
  assign slv_adr_o   = r_adr;
  assign slv_dat_o   = r_dat;
  assign err_unmap_o = r_err_unmap;
  assign err_tmo_o   = r_err_tmo;
  assign err_page_o  = r_err_page;

endmodule

// File: tb/tb_user_wb_page_sequencer.sv
`timescale 1ns/1ps
// Scoreboarded random bench for user_wb_page_sequencer: the stimulus thread pushes the expected
// master response per transfer, an independent monitor pops on every wbs_ack_o.
module tb_user_wb_page_sequencer;

  localparam int          NUM_SLV = 2;
  localparam int          TIMEOUT = 8;
  localparam logic [7:0]  PLO     = 8'h80;
  localparam logic [7:0]  PHI     = 8'hC7;
  localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        slv_cyc_o;
  logic [1:0]  slv_stb_o;
  logic        slv_we_o;
  logic [3:0]  slv_sel_o;
  logic [31:0] slv_adr_o, slv_dat_o;
  logic [1:0]  slv_ack_i = '0;
  logic [63:0] slv_dat_i = '0;
  logic        err_clr = 1'b0;
  logic        err_unmap_o, err_tmo_o;
  logic [3:0]  err_page_o;

  always #5 clk = ~clk;

  user_wb_page_sequencer #(
    .NUM_SLV(NUM_SLV), .PAGE_LO(PLO), .PAGE_HI(PHI), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .slv_cyc_o(slv_cyc_o), .slv_stb_o(slv_stb_o), .slv_we_o(slv_we_o),
    .slv_sel_o(slv_sel_o), .slv_adr_o(slv_adr_o), .slv_dat_o(slv_dat_o),
    .slv_ack_i(slv_ack_i), .slv_dat_i(slv_dat_i),
    .err_clr_i(err_clr), .err_unmap_o(err_unmap_o), .err_tmo_o(err_tmo_o),
    .err_page_o(err_page_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic        exp_unmap = 1'b0;
  logic        exp_tmo   = 1'b0;
  logic [3:0]  exp_page  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest-indexed slave whose inclusive page range contains the page, or -1.
  function automatic int ref_slave(input logic [3:0] page);
    logic [7:0] lo, hi;
    lo = PLO;
    hi = PHI;
    for (int k = 0; k < NUM_SLV; k++)
      if (page >= lo[4*k +: 4] && page <= hi[4*k +: 4]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wbs_ack_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wbs_dat_o);
        end else begin
          chk("ack_data", wbs_dat_o, exp_q.pop_front());
        end
      end else begin
        chk("dat_zero_without_ack", wbs_dat_o, 32'd0);
      end
    end
  end

  task automatic chk_flags();
    chk("err_unmap", 32'(err_unmap_o), 32'(exp_unmap));
    chk("err_tmo",   32'(err_tmo_o),   32'(exp_tmo));
    chk("err_page",  32'(err_page_o),  32'(exp_page));
  endtask

  // dly: active-cycle index on which the selected slave acks (>= TIMEOUT means never);
  // abort: master drops cyc on active cycle dly instead.
  task automatic xfer(input logic [3:0] page, input logic w, input int dly,
                      input bit abort, input bit clr_err);
    int          k;
    int          other;
    logic [31:0] a, rd, wd;
    logic [3:0]  s;
    logic [1:0]  oh;
    k  = ref_slave(page);
    a  = 32'h3000_0000 | {12'h0, page, 16'h0} | ($urandom & 32'h0000_FFFC);
    wd = $urandom;
    rd = $urandom;
    s  = 4'($urandom);
    if (!abort) begin
      if (k < 0)              exp_q.push_back(ERRD);
      else if (dly < TIMEOUT) exp_q.push_back(w ? 32'd0 : rd);
      else                    exp_q.push_back(ERRD);
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = wd;
    @(posedge clk); #1;
    if (k < 0) begin
      chk("unmap_no_stb", 32'(slv_stb_o), 32'd0);
      chk("unmap_ack_timing", 32'(wbs_ack_o), 32'd1);
      if (clr_err) err_clr = 1'b1;
    end else begin
      oh = '0;
      oh[k] = 1'b1;
      chk("slv_stb_first", 32'(slv_stb_o), 32'(oh));
      chk("slv_cyc", 32'(slv_cyc_o), 32'd1);
      chk("slv_adr", slv_adr_o, a);
      chk("slv_dat", slv_dat_o, wd);
      chk("slv_we",  32'(slv_we_o), 32'(w));
      chk("slv_sel", 32'(slv_sel_o), 32'(s));
      for (int i = 0; i < TIMEOUT; i++) begin
        @(negedge clk);
        other = 1 - k;
        if (abort && i == dly) begin
          cyc = 1'b0;
          stb = 1'b0;
        end else if (!abort && i == dly) begin
          slv_ack_i[k] = 1'b1;
          slv_dat_i[32*k +: 32] = rd;
        end
        if (!(i == dly && !abort) && $urandom_range(0, 3) == 0) begin
          slv_ack_i[other] = 1'b1;
          slv_dat_i[32*other +: 32] = $urandom;
        end
        @(posedge clk); #1;
        slv_ack_i = '0;
        if (abort && i == dly) begin
          chk("abort_cyc_low", 32'(slv_cyc_o), 32'd0);
          chk("abort_no_ack", 32'(wbs_ack_o), 32'd0);
          return;
        end
        if (i == dly || i == TIMEOUT - 1) begin
          chk("stb_dropped_on_ack", 32'(slv_stb_o), 32'd0);
          chk("ack_timing", 32'(wbs_ack_o), 32'd1);
          if (clr_err) err_clr = 1'b1;
          break;
        end
        chk("stb_held", 32'(slv_stb_o), 32'(oh));
      end
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    if (clr_err) begin
      exp_unmap = 1'b0;
      exp_tmo   = 1'b0;
    end
    if (k < 0) begin
      exp_unmap = 1'b1;
      exp_page  = page;
    end else if (dly >= TIMEOUT) begin
      exp_tmo  = 1'b1;
      exp_page = page;
    end
    chk("ack_single_pulse", 32'(wbs_ack_o), 32'd0);
    chk_flags();
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr   = 1'b0;
    exp_unmap = 1'b0;
    exp_tmo   = 1'b0;
    chk_flags();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(wbs_ack_o), 32'd0);
    chk({tag, "_dat"},   wbs_dat_o, 32'd0);
    chk({tag, "_cyc"},   32'(slv_cyc_o), 32'd0);
    chk({tag, "_stb"},   32'(slv_stb_o), 32'd0);
    chk({tag, "_we"},    32'(slv_we_o), 32'd0);
    chk({tag, "_sel"},   32'(slv_sel_o), 32'd0);
    chk({tag, "_adr"},   slv_adr_o, 32'd0);
    chk({tag, "_wdat"},  slv_dat_o, 32'd0);
    chk({tag, "_unmap"}, 32'(err_unmap_o), 32'd0);
    chk({tag, "_tmo"},   32'(err_tmo_o), 32'd0);
    chk({tag, "_page"},  32'(err_page_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] pg;
    int         d;
    bit         ab;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    xfer(4'h3, 1'b0, 1, 1'b0, 1'b0);           // read slave0, ack after two strobed cycles
    xfer(4'hA, 1'b1, 0, 1'b0, 1'b0);           // write slave1, immediate ack
    xfer(4'hE, 1'b0, 0, 1'b0, 1'b0);           // unmapped
    clear_flags();
    xfer(4'h2, 1'b0, TIMEOUT, 1'b0, 1'b0);     // slave never acks
    xfer(4'h5, 1'b0, TIMEOUT - 1, 1'b0, 1'b0); // ack on the watchdog cycle wins
    xfer(4'hD, 1'b0, 0, 1'b0, 1'b1);           // clear coincident with a new error
    xfer(4'h4, 1'b0, 2, 1'b1, 1'b0);           // master abort
    xfer(4'h1, 1'b0, 1, 1'b0, 1'b0);           // back-to-back pair
    xfer(4'h9, 1'b0, 0, 1'b0, 1'b0);
    xfer(4'hC, 1'b0, 0, 1'b0, 1'b0);           // top of slave1 range
    xfer(4'h0, 1'b1, 3, 1'b0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      pg = 4'($urandom_range(0, 15));
      ab = (ref_slave(pg) >= 0) && ($urandom_range(0, 9) == 0);
      d  = ab ? $urandom_range(0, TIMEOUT - 2) : $urandom_range(0, TIMEOUT);
      xfer(pg, 1'($urandom_range(0, 1)), d, ab, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) clear_flags();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of an ACTIVE transfer, with error flags set beforehand.
    xfer(4'hF, 1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3006_0010; wdat = 32'hCAFE_0001;
    @(posedge clk); #1;
    chk("pre_reset_active", 32'(slv_cyc_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    cyc = 1'b0; stb = 1'b0;
    exp_unmap = 1'b0; exp_tmo = 1'b0; exp_page = '0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(4'h7, 1'b0, 1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
